// File: rtl/multi_glyph_box_drawer_pkg.sv
// Shared types and default geometry for the multi-glyph box drawer and the
// glyph colour lookup that other sprite drawers reuse.
package mgbd_pkg;

  typedef enum logic [1:0] {
    GLYPH_PLUS   = 2'd0,
    GLYPH_MINUS  = 2'd1,
    GLYPH_SOLID  = 2'd2,
    GLYPH_HOLLOW = 2'd3
  } glyph_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam int         DEF_CELL      = 10;
  localparam int         DEF_GLYPH     = 9;
  localparam int         DEF_X_OFFSET  = 80;
  localparam logic [2:0] DEF_BG_COLOUR = 3'b111;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_glyph_box_drawer_if.sv
// Box request and pixel write bundle between the game FSM, the drawer and
// the VGA write mux.
interface mgbd_if #(
  parameter int NUM_BOXES = 4,
  parameter int COORD_W   = 5,
  parameter int LOC_W     = 9,
  parameter int COLOUR_W  = 3
);

  logic                            start;
  logic [NUM_BOXES-1:0]            box_valid;
  logic [NUM_BOXES*COORD_W-1:0]    box_x;
  logic [NUM_BOXES*COORD_W-1:0]    box_y;
  logic [NUM_BOXES*2-1:0]          box_glyph;
  logic [NUM_BOXES*COLOUR_W-1:0]   box_fg;
  logic                            plot_ready;
  logic [LOC_W-1:0]                xLoc;
  logic [LOC_W-1:0]                yLoc;
  logic [COLOUR_W-1:0]             colour;
  logic                            plot;
  logic                            busy;
  logic                            done;

  modport master (
    output start, box_valid, box_x, box_y, box_glyph, box_fg, plot_ready,
    input  xLoc, yLoc, colour, plot, busy, done
  );

  modport slave (
    input  start, box_valid, box_x, box_y, box_glyph, box_fg, plot_ready,
    output xLoc, yLoc, colour, plot, busy, done
  );

endinterface

// File: rtl/multi_glyph_box_drawer_glyph_colour_lut.sv
// Combinational glyph shader: picks fg or bg for pixel (cx, cy) of a glyph.
// GLYPH must be a multiple of 3 so the middle band is a clean third.
module glyph_colour_lut
  import mgbd_pkg::*;
#(
  parameter int GLYPH    = DEF_GLYPH,
  parameter int COLOUR_W = 3,
  parameter int CX_W     = clog2_min1(DEF_GLYPH)
) (
  input  glyph_e              mode_i,
  input  logic [CX_W-1:0]     cx_i,
  input  logic [CX_W-1:0]     cy_i,
  input  logic [COLOUR_W-1:0] fg_i,
  input  logic [COLOUR_W-1:0] bg_i,
  output logic [COLOUR_W-1:0] colour_o
);

  localparam logic [CX_W-1:0] BAND_LO = CX_W'(GLYPH / 3);
  localparam logic [CX_W-1:0] BAND_HI = CX_W'((2 * GLYPH) / 3 - 1);
  localparam logic [CX_W-1:0] EDGE_HI = CX_W'(GLYPH - 1);

  logic cx_band_s;
  logic cy_band_s;
  logic edge_s;
  logic fg_sel_s;

  // Classify the pixel against the band and border, then apply the mode.
  always_comb begin
    cx_band_s = (cx_i >= BAND_LO) && (cx_i <= BAND_HI);
    cy_band_s = (cy_i >= BAND_LO) && (cy_i <= BAND_HI);
    edge_s    = (cx_i == '0) || (cy_i == '0) || (cx_i == EDGE_HI) || (cy_i == EDGE_HI);
    case (mode_i)
      GLYPH_PLUS:   fg_sel_s = cx_band_s | cy_band_s;
      GLYPH_MINUS:  fg_sel_s = cy_band_s;
      GLYPH_SOLID:  fg_sel_s = 1'b1;
      GLYPH_HOLLOW: fg_sel_s = edge_s;
      default:      fg_sel_s = 1'b0;
    endcase
    colour_o = fg_sel_s ? fg_i : bg_i;
  end

endmodule

// File: rtl/multi_glyph_box_drawer.sv
// Draws up to NUM_BOXES glyph boxes back to back into the frame-buffer write
// port, one pixel per accepted plot/plot_ready beat.
module multi_glyph_box_drawer
  import mgbd_pkg::*;
#(
  parameter int                  NUM_BOXES = 4,
  parameter int                  COORD_W   = 5,
  parameter int                  LOC_W     = 9,
  parameter int                  COLOUR_W  = 3,
  parameter int                  CELL      = DEF_CELL,
  parameter int                  GLYPH     = DEF_GLYPH,
  parameter int                  X_OFFSET  = DEF_X_OFFSET,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = COLOUR_W'(DEF_BG_COLOUR)
) (
  input logic   clk,
  input logic   reset,
  mgbd_if.slave bus
);

  localparam int              IDX_W  = clog2_min1(NUM_BOXES);
  localparam int              CX_W   = clog2_min1(GLYPH);
  localparam int              ADDR_W = LOC_W + 4;
  localparam logic [CX_W-1:0] LAST_C = CX_W'(GLYPH - 1);

  state_e                        state_q, state_d;
  logic [NUM_BOXES-1:0]          valid_q, valid_d;
  logic [NUM_BOXES*COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic [NUM_BOXES*2-1:0]        glyph_q, glyph_d;
  logic [NUM_BOXES*COLOUR_W-1:0] fg_q, fg_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [CX_W-1:0]               cx_q, cx_d, cy_q, cy_d;
  logic [LOC_W-1:0]              xloc_q, xloc_d, yloc_q, yloc_d;
  logic [COLOUR_W-1:0]           colour_q, colour_d;
  logic                          plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  logic                          load_pix_s, clear_pix_s;
  logic [IDX_W:0]                first_s, next_s;
  logic [NUM_BOXES*COORD_W-1:0]  src_x_s, src_y_s;
  logic [NUM_BOXES*2-1:0]        src_glyph_s;
  logic [NUM_BOXES*COLOUR_W-1:0] src_fg_s;
  logic [COORD_W-1:0]            x_a_s [NUM_BOXES];
  logic [COORD_W-1:0]            y_a_s [NUM_BOXES];
  logic [1:0]                    g_a_s [NUM_BOXES];
  logic [COLOUR_W-1:0]           fg_a_s [NUM_BOXES];
  glyph_e                        pix_glyph_s;
  logic [LOC_W-1:0]              x_sum_s, y_sum_s;
  logic [COLOUR_W-1:0]           lut_colour_s;

  // Lowest valid box at index >= lo; MSB of the result flags a hit.
  function automatic logic [IDX_W:0] find_valid(input logic [NUM_BOXES-1:0] v, input int lo);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NUM_BOXES - 1; i >= 0; i--) begin
      if (v[i] && (i >= lo)) begin
        r = {1'b1, IDX_W'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Priority encoders for the first box of a request and the box after idx_q.
  always_comb begin
    first_s = find_valid(bus.box_valid, 0);
    next_s  = find_valid(valid_q, int'(idx_q) + 1);
  end

  // Sequencing FSM: latches the request, walks cx/cy and hops between boxes.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    x_d         = x_q;
    y_d         = y_q;
    glyph_d     = glyph_q;
    fg_d        = fg_q;
    idx_d       = idx_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    plot_d      = plot_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    load_pix_s  = 1'b0;
    clear_pix_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        plot_d      = 1'b0;
        busy_d      = 1'b0;
        clear_pix_s = 1'b1;
        if (bus.start) begin
          valid_d = bus.box_valid;
          x_d     = bus.box_x;
          y_d     = bus.box_y;
          glyph_d = bus.box_glyph;
          fg_d    = bus.box_fg;
          cx_d    = '0;
          cy_d    = '0;
          if (first_s[IDX_W]) begin
            state_d     = ST_SCAN;
            idx_d       = first_s[IDX_W-1:0];
            plot_d      = 1'b1;
            busy_d      = 1'b1;
            load_pix_s  = 1'b1;
            clear_pix_s = 1'b0;
          end else begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (plot_q && bus.plot_ready) begin
          load_pix_s = 1'b1;
          if (cx_q != LAST_C) begin
            cx_d = cx_q + CX_W'(1);
          end else if (cy_q != LAST_C) begin
            cx_d = '0;
            cy_d = cy_q + CX_W'(1);
          end else begin
            cx_d = '0;
            cy_d = '0;
            if (next_s[IDX_W]) begin
              idx_d = next_s[IDX_W-1:0];
            end else begin
              state_d     = ST_FINISH;
              plot_d      = 1'b0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
              load_pix_s  = 1'b0;
              clear_pix_s = 1'b1;
            end
          end
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_FINISH: begin
        state_d     = ST_IDLE;
        plot_d      = 1'b0;
        busy_d      = 1'b0;
        clear_pix_s = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        plot_d      = 1'b0;
        busy_d      = 1'b0;
        clear_pix_s = 1'b1;
      end
    endcase
  end

  // The first pixel of a request is built from the live inputs, the rest from the latch.
  always_comb begin
    src_x_s     = (state_q == ST_IDLE) ? bus.box_x     : x_q;
    src_y_s     = (state_q == ST_IDLE) ? bus.box_y     : y_q;
    src_glyph_s = (state_q == ST_IDLE) ? bus.box_glyph : glyph_q;
    src_fg_s    = (state_q == ST_IDLE) ? bus.box_fg    : fg_q;
    for (int i = 0; i < NUM_BOXES; i++) begin
      x_a_s[i]  = src_x_s[i*COORD_W +: COORD_W];
      y_a_s[i]  = src_y_s[i*COORD_W +: COORD_W];
      g_a_s[i]  = src_glyph_s[i*2 +: 2];
      fg_a_s[i] = src_fg_s[i*COLOUR_W +: COLOUR_W];
    end
    pix_glyph_s = glyph_e'(g_a_s[idx_d]);
    x_sum_s = LOC_W'(ADDR_W'(X_OFFSET) + ADDR_W'(x_a_s[idx_d]) * ADDR_W'(CELL) + ADDR_W'(cx_d));
    y_sum_s = LOC_W'(ADDR_W'(y_a_s[idx_d]) * ADDR_W'(CELL) + ADDR_W'(cy_d));
  end

  glyph_colour_lut #(
    .GLYPH    (GLYPH),
    .COLOUR_W (COLOUR_W),
    .CX_W     (CX_W)
  ) u_lut (
    .mode_i   (pix_glyph_s),
    .cx_i     (cx_d),
    .cy_i     (cy_d),
    .fg_i     (fg_a_s[idx_d]),
    .bg_i     (BG_COLOUR),
    .colour_o (lut_colour_s)
  );

  // Pixel output staging: address and colour always move together.
  always_comb begin
    if (load_pix_s) begin
      xloc_d   = x_sum_s;
      yloc_d   = y_sum_s;
      colour_d = lut_colour_s;
    end else if (clear_pix_s) begin
      xloc_d   = '0;
      yloc_d   = '0;
      colour_d = '0;
    end else begin
      xloc_d   = xloc_q;
      yloc_d   = yloc_q;
      colour_d = colour_q;
    end
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      valid_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      glyph_q  <= '0;
      fg_q     <= '0;
      idx_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      xloc_q   <= '0;
      yloc_q   <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      x_q      <= x_d;
      y_q      <= y_d;
      glyph_q  <= glyph_d;
      fg_q     <= fg_d;
      idx_q    <= idx_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      xloc_q   <= xloc_d;
      yloc_q   <= yloc_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.xLoc   = xloc_q;
  assign bus.yLoc   = yloc_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_multi_glyph_box_drawer.sv
// Scoreboard bench: a pixel-list model queues every expected write at start,
// a negedge monitor pops and compares on each accepted beat.
module tb_multi_glyph_box_drawer;

  localparam int NB = 4;
  localparam int CW = 5;
  localparam int LW = 9;
  localparam int COLW = 3;
  localparam int G = 9;

  typedef struct packed {
    logic [LW-1:0]   x;
    logic [LW-1:0]   y;
    logic [COLW-1:0] c;
  } pix_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mgbd_if #(.NUM_BOXES(NB), .COORD_W(CW), .LOC_W(LW), .COLOUR_W(COLW)) bus ();

  multi_glyph_box_drawer #(
    .NUM_BOXES(NB), .COORD_W(CW), .LOC_W(LW), .COLOUR_W(COLW),
    .CELL(10), .GLYPH(G), .X_OFFSET(80), .BG_COLOUR(3'b111)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass = 0;
  pix_t exp_q[$];
  int beats = 0;
  int busy_cycles = 0;
  int done_cnt = 0;
  int exp_beats = 0;
  bit mon_en = 1'b0;
  int rdy_mode = 0;
  bit pbeat = 1'b0;
  int bx[NB];
  int by[NB];
  int bm[NB];
  logic [COLW-1:0] bf[NB];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference shading: the middle third is where 3*v/G lands on 1.
  function automatic logic [COLW-1:0] ref_colour(input int mode, input int cx, input int cy,
                                                 input logic [COLW-1:0] fg);
    bit in_x, in_y, border, on;
    in_x = ((3 * cx) / G) == 1;
    in_y = ((3 * cy) / G) == 1;
    border = (cx == 0) || (cy == 0) || (cx == G - 1) || (cy == G - 1);
    case (mode)
      0: on = in_x || in_y;
      1: on = in_y;
      2: on = 1'b1;
      default: on = border;
    endcase
    return on ? fg : 3'b111;
  endfunction

  task automatic set_box(input int i, input int x, input int y, input int m, input logic [COLW-1:0] fg);
    bx[i] = x; by[i] = y; bm[i] = m; bf[i] = fg;
  endtask

  task automatic random_boxes();
    for (int i = 0; i < NB; i++)
      set_box(i, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 3), 3'($urandom_range(0, 7)));
  endtask

  task automatic start_run(input logic [NB-1:0] valid);
    pix_t p;
    @(posedge clk); #1;
    bus.box_valid = valid;
    for (int i = 0; i < NB; i++) begin
      bus.box_x[i*CW +: CW] = CW'(bx[i]);
      bus.box_y[i*CW +: CW] = CW'(by[i]);
      bus.box_glyph[i*2 +: 2] = 2'(bm[i]);
      bus.box_fg[i*COLW +: COLW] = bf[i];
    end
    bus.start = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NB; i++) begin
      if (valid[i]) begin
        for (int cy = 0; cy < G; cy++) begin
          for (int cx = 0; cx < G; cx++) begin
            p.x = LW'((80 + bx[i] * 10 + cx) % 512);
            p.y = LW'((by[i] * 10 + cy) % 512);
            p.c = ref_colour(bm[i], cx, cy, bf[i]);
            exp_q.push_back(p);
          end
        end
      end
    end
    exp_beats = exp_q.size();
    beats = 0;
    busy_cycles = 0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.box_valid = NB'($urandom);
    bus.box_x = (NB*CW)'($urandom);
    bus.box_y = (NB*CW)'($urandom);
    bus.box_glyph = (NB*2)'($urandom);
    bus.box_fg = (NB*COLW)'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("done_seen", done_cnt != d0, 1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (beats < target && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("reach_beat", beats >= target, 1);
  endtask

  // Backpressure: always ready, strict toggle, or random.
  initial begin
    bus.plot_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.plot_ready = 1'b1;
        1: bus.plot_ready = ~bus.plot_ready;
        default: bus.plot_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare the presented pixel to the queue head; pop on accept.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.done) begin
        done_cnt++;
        if (mon_en) begin
          chk("done_after_last_beat", pbeat, exp_beats > 0);
          chk("done_queue_empty", exp_q.size(), 0);
        end
      end
      if (mon_en && bus.busy) chk("busy_implies_plot", bus.plot, 1);
      if (mon_en && bus.plot) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_plot", 1, 0);
        end else begin
          chk("xLoc", bus.xLoc, exp_q[0].x);
          chk("yLoc", bus.yLoc, exp_q[0].y);
          chk("colour", bus.colour, exp_q[0].c);
          if (bus.plot_ready) begin
            void'(exp_q.pop_front());
            beats++;
          end
        end
      end
      if (bus.busy) busy_cycles++;
      pbeat = bus.plot && bus.plot_ready;
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.box_valid = '0;
    bus.box_x = '0;
    bus.box_y = '0;
    bus.box_glyph = '0;
    bus.box_fg = '0;
    for (int i = 0; i < NB; i++) set_box(i, 0, 0, 0, 3'b000);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_xLoc", bus.xLoc, 0);
    chk("rst_yLoc", bus.yLoc, 0);
    chk("rst_colour", bus.colour, 0);
    chk("rst_plot", bus.plot, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    mon_en = 1'b1;

    // Single PLUS box at (2,3)
    set_box(0, 2, 3, 0, 3'b010);
    start_run(4'b0001);
    chk("t1_first_x", bus.xLoc, 100);
    chk("t1_first_y", bus.yLoc, 30);
    chk("t1_first_c", bus.colour, 7);
    chk("t1_first_plot", bus.plot, 1);
    wait_done(400);
    chk("t1_beats", beats, 81);

    // MINUS in box1 then SOLID in box3, no gap between
    random_boxes();
    set_box(1, 4, 7, 1, 3'b100);
    set_box(3, 12, 5, 2, 3'b001);
    start_run(4'b1010);
    wait_done(800);
    chk("t2_beats", beats, 162);
    chk("t2_busy_cycles", busy_cycles, 162);

    // Nothing valid: done on the next cycle, no plot
    start_run(4'b0000);
    chk("t3_done_next", bus.done, 1);
    chk("t3_no_plot", bus.plot, 0);
    wait_done(5);
    chk("t3_beats", beats, 0);

    // HOLLOW under toggling backpressure
    rdy_mode = 1;
    set_box(2, 9, 20, 3, 3'b011);
    start_run(4'b0100);
    wait_done(800);
    chk("t4_beats", beats, 81);
    rdy_mode = 0;

    // Reset mid-draw at beat 40
    set_box(0, 1, 1, 0, 3'b101);
    start_run(4'b0001);
    wait_beats(40);
    #1;
    reset = 1'b1;
    mon_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_xLoc", bus.xLoc, 0);
    chk("t5_yLoc", bus.yLoc, 0);
    chk("t5_colour", bus.colour, 0);
    chk("t5_plot", bus.plot, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_done", bus.done, 0);
    begin
      int d0;
      d0 = done_cnt;
      repeat (5) @(posedge clk);
      chk("t5_no_done", done_cnt, d0);
    end
    exp_q.delete();
    mon_en = 1'b1;
    set_box(0, 6, 2, 2, 3'b110);
    start_run(4'b0001);
    wait_done(400);
    chk("t5_redraw_beats", beats, 81);

    // Second start mid-draw is ignored
    set_box(0, 5, 8, 0, 3'b010);
    start_run(4'b0001);
    wait_beats(10);
    #1;
    bus.start = 1'b1;
    bus.box_valid = 4'b1111;
    bus.box_x = 20'hABCDE;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(400);
    chk("t6_beats", beats, 81);

    // Random mixes under random backpressure
    rdy_mode = 2;
    for (int r = 0; r < 4; r++) begin
      random_boxes();
      start_run(4'($urandom_range(1, 15)));
      wait_done(3000);
      chk("rnd_beats", beats, exp_beats);
    end
    rdy_mode = 0;

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
